// File: rtl/alu.sv
// alu: 32-bit datapath ALU with PC increment; result registered into 64-bit z (HI:LO).
module alu (
    input  logic        clk,
    input  logic        clr,
    input  logic        IncPC,
    input  logic [31:0] b,
    input  logic [31:0] y,
    input  logic [4:0]  opcode,
    output logic [63:0] z
);
    logic [4:0]         w_sh;
    logic [63:0]        w_bb;
    logic [63:0]        w_ror;
    logic [63:0]        w_rol;
    logic signed [63:0] w_prod;
    logic [31:0]        w_q;
    logic [31:0]        w_r;
    logic [63:0]        w_res;

    assign w_sh   = y[4:0];
    assign w_bb   = {b, b};
    assign w_ror  = w_bb >> w_sh;
    assign w_rol  = w_bb << w_sh;
    assign w_prod = 64'($signed(y)) * 64'($signed(b));

    // Zero divisor and the single overflowing pair get fixed results instead of the operator
    always_comb begin
        w_q = 32'hFFFF_FFFF;
        w_r = y;
        if (b == 32'd0) begin
            w_q = 32'hFFFF_FFFF;
            w_r = y;
        end else if (y == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            w_q = 32'h8000_0000;
            w_r = 32'd0;
        end else begin
            w_q = 32'($signed(y) / $signed(b));
            w_r = 32'($signed(y) % $signed(b));
        end
    end

    always_comb begin
        w_res = 64'd0;
        case (opcode)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd12: w_res = {32'd0, y + b};
            5'd4:                          w_res = {32'd0, y - b};
            5'd5, 5'd13:                   w_res = {32'd0, y & b};
            5'd6, 5'd14:                   w_res = {32'd0, y | b};
            5'd7:                          w_res = {32'd0, b >> w_sh};
            5'd8:                          w_res = {32'd0, 32'($signed(b) >>> w_sh)};
            5'd9:                          w_res = {32'd0, b << w_sh};
            5'd10:                         w_res = {32'd0, w_ror[31:0]};
            5'd11:                         w_res = {32'd0, w_rol[63:32]};
            5'd15:                         w_res = w_prod;
            5'd16:                         w_res = {w_r, w_q};
            5'd17:                         w_res = {32'd0, 32'd0 - y};
            5'd18:                         w_res = {32'd0, ~y};
            default:                       w_res = 64'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr)
            z <= 64'd0;
        else if (IncPC)
            z <= {32'd0, b + 32'd1};
        else
            z <= w_res;
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed plan vectors plus random stimulus against an arithmetic reference model.
module tb_alu;
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        IncPC = 1'b0;
    logic [31:0] b = '0;
    logic [31:0] y = '0;
    logic [4:0]  opcode = '0;
    logic [63:0] z;
    int          n_tests = 0;
    int          n_fail = 0;

    alu dut (
        .clk(clk), .clr(clr), .IncPC(IncPC), .b(b), .y(y), .opcode(opcode), .z(z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %016h expected %016h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit inc, input logic [4:0] op,
                                          input logic [31:0] bv, input logic [31:0] yv);
        longint      sb = longint'($signed(bv));
        longint      sy = longint'($signed(yv));
        longint      ub = longint'(bv);
        int          s  = int'(yv[4:0]);
        logic [31:0] r  = bv;
        if (inc) return {32'd0, bv + 32'd1};
        case (op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd12: r = 32'(sy + sb);
            5'd4:  r = 32'(sy - sb);
            5'd5, 5'd13: r = yv & bv;
            5'd6, 5'd14: r = yv | bv;
            5'd7:  r = 32'(ub / (longint'(1) << s));
            5'd8:  r = 32'(sb >>> s);
            5'd9:  r = 32'(ub * (longint'(1) << s));
            5'd10: for (int i = 0; i < s; i++) r = {r[0], r[31:1]};
            5'd11: for (int i = 0; i < s; i++) r = {r[30:0], r[31]};
            5'd15: return 64'(sy * sb);
            5'd16: begin
                if (bv == 32'd0) return {yv, 32'hFFFF_FFFF};
                return {32'(sy % sb), 32'(sy / sb)};
            end
            5'd17: r = 32'(-sy);
            5'd18: r = ~yv;
            default: return 64'd0;
        endcase
        return {32'd0, r};
    endfunction

    task automatic step(input bit c, input bit inc, input logic [4:0] op,
                        input logic [31:0] bv, input logic [31:0] yv,
                        input logic [63:0] exp, input string tag);
        clr = c; IncPC = inc; opcode = op; b = bv; y = yv;
        @(posedge clk);
        #1;
        check(tag, z, exp);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        step(0, 0, 5'd3, 32'h14, 32'd4, 64'd0, "reset1");
        step(0, 0, 5'd3, 32'h14, 32'd4, 64'd0, "reset2");
        step(1, 1, 5'd3, 32'h100, 32'd4, 64'h101, "incpc");
        step(1, 0, 5'd3, 32'h12, 32'h14, 64'h26, "add");
        step(1, 0, 5'd4, 32'd15, 32'd4, 64'h0000_0000_FFFF_FFF5, "sub");
        step(1, 0, 5'd5, 32'h19, 32'h53, 64'h11, "and");
        step(1, 0, 5'd6, 32'h11, 32'hF2, 64'hF3, "or");
        step(1, 0, 5'd31, 32'h11, 32'hF2, 64'd0, "undef");
        step(1, 0, 5'd7, 32'h1000_0000, 32'd1, 64'h0800_0000, "shr");
        step(1, 0, 5'd8, 32'hF000_0000, 32'd4, 64'hFF00_0000, "shra");
        step(1, 0, 5'd9, 32'd1, 32'd2, 64'd4, "shl");
        step(1, 0, 5'd10, 32'd1, 32'd1, 64'h8000_0000, "ror");
        step(1, 0, 5'd11, 32'h8000_0000, 32'h21, 64'd1, "rol");
        step(1, 0, 5'd10, 32'h1234_5678, 32'h20, 64'h1234_5678, "ror0");
        step(1, 0, 5'd15, 32'd12, 32'd4, 64'd48, "mul");
        step(1, 0, 5'd15, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, "mulneg");
        step(1, 0, 5'd15, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mulmin");
        step(0, 0, 5'd15, 32'd12, 32'd4, 64'd0, "rstmul");
        step(1, 0, 5'd16, 32'd12, 32'd27, 64'h0000_0003_0000_0002, "div");
        step(1, 0, 5'd16, 32'd2, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFD, "divneg");
        step(1, 0, 5'd16, 32'd0, 32'd9, 64'h0000_0009_FFFF_FFFF, "div0");
        step(1, 0, 5'd16, 32'hFFFF_FFFF, 32'h8000_0000, 64'h0000_0000_8000_0000, "divovf");
        step(1, 0, 5'd17, 32'd0, 32'd5, 64'h0000_0000_FFFF_FFFB, "neg");
        step(1, 0, 5'd18, 32'd0, 32'hFFFF_FF00, 64'hFF, "not");
        step(0, 1, 5'd3, 32'h100, 32'd4, 64'd0, "rstinc");
        step(1, 1, 5'd16, 32'h7, 32'd9, 64'h8, "incdiv");
        for (int i = 0; i < 600; i++) begin
            bit          c   = ($urandom_range(0, 19) != 0);
            bit          inc = ($urandom_range(0, 9) == 0);
            logic [4:0]  op  = 5'($urandom_range(0, 31));
            logic [31:0] bv  = pick();
            logic [31:0] yv  = pick();
            step(c, inc, op, bv, yv, c ? model(inc, op, bv, yv) : 64'd0, $sformatf("rnd%0d_op%0d", i, op));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
